// File: rtl/trng_req_scheduler.sv
// trng_req_scheduler: round-robin arbiter sharing one TRNG core between NUM_REQ requesters.
// Latency: grant accepted in IDLE -> CFG next cycle -> WAIT; gnt_valid one cycle after the accepted core_valid.
// Backpressure: level req is held until its gnt_valid bit; no new grant is taken while busy.
//
// Ports:
//   clk, areset                 clock, asynchronous active-high reset
//   req / req_low / req_high     per-requester level request and [low, high) range, 32-bit slices
//   gnt_valid/data/raw/err       registered one-hot completion pulse with mapped/raw word and error flag
//   err_cnt, busy                saturating error-response count, state != IDLE
//   core_*                       TRNG core control (enable, range load, alarm clear) and status inputs
//
// Optional macro TRNG_SCHED_STARTUP_EN: after reset the core runs in a STARTUP state that
// discards STARTUP_WORDS fresh words before the first request is served.

module trng_req_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_CYC   = 1000000,
  parameter int STARTUP_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_low,
  input  logic [32*NUM_REQ-1:0]  req_high,
  output logic [NUM_REQ-1:0]     gnt_valid,
  output logic [31:0]            gnt_data,
  output logic [31:0]            gnt_raw,
  output logic                   gnt_err,
  output logic [7:0]             err_cnt,
  output logic                   busy,
  output logic                   core_enable,
  output logic                   core_update_range,
  output logic [31:0]            core_new_low,
  output logic [31:0]            core_new_high,
  output logic                   core_clr_alarms,
  input  logic                   core_valid,
  input  logic [31:0]            core_random_raw,
  input  logic [31:0]            core_random_in_range,
  input  logic                   core_health_ok
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 1);

  // Elaboration-time parameter range guard.
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 16777216 ||
        STARTUP_WORDS < 1) begin : g_bad_param
      $error("trng_req_scheduler: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_WAIT,
    ST_RESP,
    ST_ERR,
    ST_STARTUP
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [23:0]      r_timer;
`ifdef TRNG_SCHED_STARTUP_EN
  localparam logic [15:0] SU_LAST = 16'(STARTUP_WORDS - 1);
  logic [15:0]      r_su_cnt;
`endif

  // Per-requester range views.
  logic [31:0] w_low  [NUM_REQ];
  logic [31:0] w_high [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_low[gi]  = req_low[32*gi +: 32];
      assign w_high[gi] = req_high[32*gi +: 32];
    end
  endgenerate

  // Requests rotated so bit 0 is the requester at rr_ptr; the lowest set bit
  // of the rotated vector is the round-robin winner.
  logic [NUM_REQ-1:0] w_req_rot;
  logic               w_pick_any;
  logic [IDX_W-1:0]   w_pick_off;
  logic [IDX_W:0]     w_pick_sum;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_idx_onehot;
  logic [IDX_W-1:0]   w_rr_next;

  assign w_req_rot = NUM_REQ'({req, req} >> r_rr_ptr);

  always_comb begin
    w_pick_any = 1'b0;
    w_pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_pick_any = 1'b1;
        w_pick_off = IDX_W'(k);
      end
    end
    // (rr_ptr + offset) mod NUM_REQ, valid for non-power-of-two NUM_REQ too.
    w_pick_sum = {1'b0, r_rr_ptr} + {1'b0, w_pick_off};
    if (w_pick_sum >= (IDX_W+1)'(NUM_REQ)) begin
      w_pick_sum = w_pick_sum - (IDX_W+1)'(NUM_REQ);
    end
    w_pick_idx = w_pick_sum[IDX_W-1:0];
  end

  assign w_idx_onehot = NUM_REQ'(1) << r_idx;
  assign w_rr_next    = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
`ifdef TRNG_SCHED_STARTUP_EN
      r_state     <= ST_STARTUP;
      busy        <= 1'b1;
      core_enable <= 1'b1;
      r_su_cnt    <= '0;
`else
      r_state     <= ST_IDLE;
      busy        <= 1'b0;
      core_enable <= 1'b0;
`endif
      r_rr_ptr          <= '0;
      r_idx             <= '0;
      r_timer           <= '0;
      gnt_valid         <= '0;
      gnt_data          <= '0;
      gnt_raw           <= '0;
      gnt_err           <= 1'b0;
      err_cnt           <= '0;
      core_update_range <= 1'b0;
      core_new_low      <= '0;
      core_new_high     <= '0;
      core_clr_alarms   <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      core_update_range <= 1'b0;
      core_clr_alarms   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // core_enable is already 0 here, so the core accumulator is flushed
          // and the next word is fresh.
          if (w_pick_any) begin
            r_idx             <= w_pick_idx;
            core_new_low      <= w_low[w_pick_idx];
            core_new_high     <= w_high[w_pick_idx];
            core_update_range <= 1'b1;
            core_enable       <= 1'b1;
            busy              <= 1'b1;
            r_state           <= ST_CFG;
          end
        end

        ST_CFG: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A fresh healthy word wins over both alarm and timeout expiry.
          if (core_valid && core_health_ok) begin
            gnt_valid   <= w_idx_onehot;
            gnt_data    <= core_random_in_range;
            gnt_raw     <= core_random_raw;
            gnt_err     <= 1'b0;
            core_enable <= 1'b0;
            r_state     <= ST_RESP;
          end else if (!core_health_ok || (r_timer == TMO_LAST)) begin
            gnt_valid       <= w_idx_onehot;
            gnt_data        <= '0;
            gnt_raw         <= '0;
            gnt_err         <= 1'b1;
            core_clr_alarms <= 1'b1;
            core_enable     <= 1'b0;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            r_state <= ST_ERR;
          end else begin
            r_timer <= r_timer + 24'd1;
          end
        end

        ST_RESP, ST_ERR: begin
          gnt_valid <= '0;
          gnt_data  <= '0;
          gnt_raw   <= '0;
          gnt_err   <= 1'b0;
          busy      <= 1'b0;
          r_rr_ptr  <= w_rr_next;
          r_state   <= ST_IDLE;
        end

`ifdef TRNG_SCHED_STARTUP_EN
        ST_STARTUP: begin
          // Discard the first words after reset; an alarm restarts the count.
          if (!core_health_ok) begin
            core_clr_alarms <= 1'b1;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            r_su_cnt <= '0;
          end else if (core_valid) begin
            if (r_su_cnt == SU_LAST) begin
              r_su_cnt    <= '0;
              core_enable <= 1'b0;
              busy        <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_su_cnt <= r_su_cnt + 16'd1;
            end
          end
        end
`endif

        default: begin
          core_enable <= 1'b0;
          busy        <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/trng_req_scheduler.md
Name: trng_req_scheduler

Overview:
- Round-robin scheduler that shares one TRNG core between NUM_REQ requesters.
- Each requester supplies its own [low, high) range.
- Per granted request, the block:
  - programs the core range;
  - enables the core for one fresh 32-bit word;
  - returns the mapped and raw values to that requester.
- Handles health-alarm recovery and no-data timeout. Sits between the TRNG core and the AXI register/front-end logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 1000000, WAIT-state cycles before error response (>=2, fits 24 bits).
- STARTUP_WORDS, 4, words discarded after reset (used only with optional feature).

Ports:
- clk  in  1  system clock
- areset  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  per-requester level request; held until its gnt_valid bit
- req_low  in  32*NUM_REQ  range low bound; slice i = [32*i+31:32*i]; stable while req[i]=1
- req_high  in  32*NUM_REQ  range high bound (exclusive), same slicing
- gnt_valid  out  NUM_REQ  one-cycle completion pulse, one-hot
- gnt_data  out  32  mapped random value, valid with gnt_valid
- gnt_raw  out  32  raw random word, valid with gnt_valid
- gnt_err  out  1  1 = request failed (health alarm or timeout), valid with gnt_valid
- err_cnt  out  8  saturating count of error responses
- busy  out  1  state != IDLE
- core_enable  out  1  TRNG core enable
- core_update_range  out  1  one-cycle range load pulse
- core_new_low  out  32  range low to core
- core_new_high  out  32  range high to core
- core_clr_alarms  out  1  one-cycle alarm clear pulse
- core_valid  in  1  core fresh-word strobe
- core_random_raw  in  32  core raw word
- core_random_in_range  in  32  core mapped word
- core_health_ok  in  1  core health status

Behaviour:
- Reset (async, areset=1):
  - state IDLE; rr_ptr=0.
  - All outputs 0: gnt_valid, gnt_data, gnt_raw, gnt_err, err_cnt, busy, core_enable, core_update_range, core_new_low, core_new_high, core_clr_alarms.
  - Reset mid-transaction aborts it; no gnt_valid is emitted.
- States: IDLE, CFG, WAIT, RESP, ERR.
- IDLE:
  - core_enable=0, which clears the core accumulator so every word is fresh.
  - If any req bit is set: pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; latch idx; go to CFG.
- CFG (exactly 1 cycle):
  - core_update_range=1, core_new_low/high = slice idx, core_enable=1.
  - Clear the timer; go to WAIT.
- WAIT (core_enable=1), first match wins:
  - core_valid=1 and core_health_ok=1: latch both core words; go to RESP.
  - core_health_ok=0: go to ERR.
  - timer == TIMEOUT_CYC-1: go to ERR.
  - Otherwise timer+1.
  - A core_valid in the same cycle as timeout expiry wins (RESP).
- RESP (1 cycle):
  - gnt_valid[idx]=1, gnt_data and gnt_raw = latched words, gnt_err=0, core_enable=0.
  - rr_ptr = (idx+1) mod NUM_REQ; go to IDLE.
- ERR (1 cycle):
  - gnt_valid[idx]=1, gnt_err=1, gnt_data=0, gnt_raw=0.
  - core_clr_alarms=1, core_enable=0.
  - err_cnt+1, saturating at 255.
  - rr_ptr advances as in RESP; go to IDLE.
- Grant outputs:
  - gnt_data, gnt_raw and gnt_err are registered.
  - They read 0 in every cycle where gnt_valid=0.
- Requester dropping req mid-transaction does not abort; the gnt_valid pulse is still issued.
- Latency: req rising in IDLE, then CFG in the next cycle, then WAIT; gnt_valid arrives 1 cycle after the accepted core_valid.
- Minimum turnaround: gnt_valid to the next CFG is 2 cycles (RESP→IDLE→CFG).
- Range sanity (high <= low) is resolved by the core; the scheduler passes values unmodified.
- core_health_ok is sampled only in WAIT.

Optional Feature:
- Macro TRNG_SCHED_STARTUP_EN.
- Defined:
  - After reset, enter a STARTUP state before IDLE, with core_enable=1 and the default range left untouched.
  - Count core_valid strobes; discard STARTUP_WORDS words; requests stay pending (busy=1).
  - core_health_ok=0 during STARTUP: pulse core_clr_alarms, increment err_cnt, restart the count.
- Undefined: reset enters IDLE directly; STARTUP logic is absent.

Test Plan:
- Bench uses a behavioural core model; valid asserts 40 cycles after enable rises.
- req=4'b0001, low=10, high=20; model returns in_range=15, raw=0xDEADBEEF → CFG drives core_new_low=10 and core_new_high=20 for 1 cycle; gnt_valid=0001, gnt_data=15, gnt_raw=0xDEADBEEF, gnt_err=0.
- req=4'b1111 held for 4 grants → grant order 0,1,2,3; next grant goes to 0 again; each grant is preceded by a core_enable low cycle.
- Model holds core_health_ok=0 during WAIT → gnt_err=1, gnt_data=0, core_clr_alarms pulses 1 cycle, err_cnt=1.
- TIMEOUT_CYC=100 and the model never asserts valid → gnt_valid with gnt_err=1 exactly 100 WAIT cycles after CFG.
- core_valid on the same cycle as timeout expiry → RESP with gnt_err=0. Separately, assert areset mid-WAIT → no gnt_valid and all outputs 0.
- With TRNG_SCHED_STARTUP_EN and STARTUP_WORDS=4 → req[0] raised at reset release is served only after 4 discarded core_valid strobes.
